// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding,
// default geometry and the slice-counter width helper.
package digit_serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   localparam int unsigned DEF_WIDTH = 16;
   localparam int unsigned DEF_DIGIT = 4;
   localparam int unsigned DEF_NDIG  = DEF_WIDTH / DEF_DIGIT;

   // A single-slice configuration still needs a 1-bit counter.
   function automatic int unsigned ctr_width(input int unsigned ndig);
      return (ndig > 1) ? $clog2(ndig) : 1;
   endfunction

endpackage

// File: rtl/digit_serial_adder_rca.sv
// DIGIT-wide combinational ripple-carry adder built from the full-adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module digit_rca #(
   parameter int unsigned DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             co
);
   logic [DIGIT:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      full_adder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   assign co = c[DIGIT];
endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle add/subtract: one DIGIT-bit slice per clock through a small
// ripple adder, carry held in a register, valid/ready on both sides.
module digit_serial_adder
   import digit_serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DIGIT = DEF_DIGIT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int unsigned NDIG = WIDTH / DIGIT;
   localparam int unsigned KW   = ctr_width(NDIG);
   localparam logic [KW-1:0] LAST = KW'(NDIG - 1);

   if (WIDTH % DIGIT != 0) begin : g_bad_geometry
      $error("digit_serial_adder: WIDTH must be a multiple of DIGIT");
   end

   state_e           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
   logic [DIGIT-1:0] a_dig, b_dig, dig_s;
   logic             dig_co;

   assign a_dig = a_q[k_q*DIGIT +: DIGIT];
   assign b_dig = b_q[k_q*DIGIT +: DIGIT];

   digit_rca #(.DIGIT(DIGIT)) u_rca (
      .a   (a_dig),
      .b   (b_dig),
      .cin (carry_q),
      .s   (dig_s),
      .co  (dig_co)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               // Subtraction runs as A + ~B + ~cin.
               a_d     = x;
               b_d     = sub ? ~y : y;
               carry_d = cin ^ sub;
               k_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[k_q*DIGIT +: DIGIT] = dig_s;
            carry_d                   = dig_co;
            if (k_q == LAST) begin
               // The final slice holds the MSB of the result.
               cout_d  = dig_co;
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (dig_s[DIGIT-1] != a_q[WIDTH-1]);
               k_d     = '0;
               state_d = DONE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: directed vectors, handshake corner cases and
// random add/sub across several WIDTH/DIGIT geometries against an integer model.
module tb_digit_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, cin, sub, out_ready;
   logic [15:0] x, y;

   logic        in_ready, out_valid, cout, ovf;
   logic [15:0] sum;
   logic        ir1, ov1, co1, of1;
   logic [15:0] s1;
   logic        ir16, ov16, co16, of16;
   logic [15:0] s16;
   logic        ir8, ov8, co8, of8;
   logic [7:0]  s8;

   int vectors     = 0;
   int miscompares = 0;

   digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

   digit_serial_adder #(.WIDTH(16), .DIGIT(1)) dut_b1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
      .x(x), .y(y), .cin(cin), .sub(sub), .out_valid(ov1),
      .out_ready(1'b1), .sum(s1), .cout(co1), .ovf(of1));

   digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut_b16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16),
      .x(x), .y(y), .cin(cin), .sub(sub), .out_valid(ov16),
      .out_ready(1'b1), .sum(s16), .cout(co16), .ovf(of16));

   digit_serial_adder #(.WIDTH(8), .DIGIT(2)) dut_w8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8),
      .x(x[7:0]), .y(y[7:0]), .cin(cin), .sub(sub), .out_valid(ov8),
      .out_ready(1'b1), .sum(s8), .cout(co8), .ovf(of8));

   typedef struct {
      logic [15:0] x, y;
      logic        cin, sub;
      logic [15:0] s;
      logic        co, of;
   } vec_t;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Integer reference: result of x +/- y +/- cin, unsigned carry/no-borrow, signed range check.
   function automatic void model(input int w, input longint unsigned xa, input longint unsigned ya,
                                 input bit c, input bit s,
                                 output longint unsigned rs, output bit rc, output bit ro);
      longint m, sx, sy, u, r;
      m  = longint'(1) << w;
      sx = (longint'(xa) >= m / 2) ? longint'(xa) - m : longint'(xa);
      sy = (longint'(ya) >= m / 2) ? longint'(ya) - m : longint'(ya);
      if (!s) begin
         u  = longint'(xa) + longint'(ya) + longint'(c);
         rc = (u >= m);
         r  = sx + sy + longint'(c);
      end else begin
         u  = longint'(xa) - longint'(ya) - longint'(c) + m;
         rc = (longint'(xa) >= longint'(ya) + longint'(c));
         r  = sx - sy - longint'(c);
      end
      rs = longint'(u % m);
      ro = (r < -(m / 2)) || (r >= m / 2);
   endfunction

   // Drive one operation into the main DUT and count edges until out_valid.
   task automatic run_op(input logic [15:0] xa, input logic [15:0] ya, input logic c,
                         input logic s, output int lat);
      x = xa; y = ya; cin = c; sub = s; in_valid = 1'b1;
      check("in_ready_at_accept", in_ready, 1);
      step;
      in_valid = 1'b0;
      x = 16'($urandom); y = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      lat = 0;
      while (lat < 40) begin
         step;
         lat++;
         if (out_valid) break;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[8];
      int   lat;
      logic [15:0] corner[4];
      longint unsigned xa, ya, es, rs[4], mask;
      bit   ec, eo, c, s;
      bit   rc[4], ro[4], seen[4];
      int   lt[4];
      int   wd[4];
      int   nd[4];

      tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[2] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      tbl[5] = '{16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0};
      tbl[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
      tbl[7] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
      corner = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
      wd = '{16, 16, 16, 8};
      nd = '{4, 16, 1, 4};

      rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      step; step;
      check("reset_out_valid", out_valid, 0);
      check("reset_in_ready", in_ready, 1);
      check("reset_sum", sum, 0);
      check("reset_cout", cout, 0);
      check("reset_ovf", ovf, 0);
      rst_n = 1'b1;
      step;

      for (int i = 0; i < 8; i++) begin
         run_op(tbl[i].x, tbl[i].y, tbl[i].cin, tbl[i].sub, lat);
         check($sformatf("tbl%0d_latency", i), lat, 4);
         check($sformatf("tbl%0d_sum", i), sum, tbl[i].s);
         check($sformatf("tbl%0d_cout", i), cout, tbl[i].co);
         check($sformatf("tbl%0d_ovf", i), ovf, tbl[i].of);
         step;
      end

      // Backpressure in DONE: outputs frozen, new operands refused.
      out_ready = 1'b0;
      run_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
      check("bp_latency", lat, 4);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; x = 16'hAAAA; y = 16'h5555;
         step;
         check($sformatf("bp%0d_out_valid", i), out_valid, 1);
         check($sformatf("bp%0d_in_ready", i), in_ready, 0);
         check($sformatf("bp%0d_sum", i), sum, 16'h2345);
         check($sformatf("bp%0d_flags", i), {cout, ovf}, 2'b00);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step;
      check("bp_release_out_valid", out_valid, 0);
      check("bp_release_in_ready", in_ready, 1);
      check("bp_release_sum_kept", sum, 16'h2345);
      run_op(16'h0F0F, 16'h00F1, 1'b1, 1'b1, lat);
      check("bp_next_latency", lat, 4);
      check("bp_next_result", {cout, ovf, sum}, {1'b1, 1'b0, 16'h0E1D});
      step;

      // Reset while slice 2 is in progress.
      x = 16'h3333; y = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      step; step;
      rst_n = 1'b0;
      step;
      rst_n = 1'b1;
      check("midrun_rst_out_valid", out_valid, 0);
      check("midrun_rst_in_ready", in_ready, 1);
      check("midrun_rst_sum", sum, 0);
      check("midrun_rst_flags", {cout, ovf}, 2'b00);
      repeat (5) step;
      check("midrun_rst_no_result", out_valid, 0);
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, lat);
      check("post_rst_latency", lat, 4);
      check("post_rst_result", {cout, ovf, sum}, {1'b1, 1'b0, 16'hFFFF});
      step;

      // Random sweep across all geometries in lock-step.
      rst_n = 1'b0;
      step;
      rst_n = 1'b1;
      step;
      for (int n = 0; n < 1000; n++) begin
         xa = 64'($urandom_range(0, 65535));
         ya = 64'($urandom_range(0, 65535));
         if ($urandom_range(0, 3) == 0) xa = 64'(corner[$urandom_range(0, 3)]);
         if ($urandom_range(0, 3) == 0) ya = 64'(corner[$urandom_range(0, 3)]);
         c = 1'($urandom);
         s = 1'($urandom);
         x = xa[15:0]; y = ya[15:0]; cin = c; sub = s; in_valid = 1'b1;
         check($sformatf("rand%0d_in_ready", n), {ir8, ir16, ir1, in_ready}, 4'hF);
         step;
         in_valid = 1'b0;
         x = 16'($urandom); y = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
         for (int i = 0; i < 4; i++) begin
            seen[i] = 1'b0; lt[i] = 0; rs[i] = 0; rc[i] = 1'b0; ro[i] = 1'b0;
         end
         for (int t = 1; t <= 18; t++) begin
            step;
            if (!seen[0] && out_valid) begin seen[0] = 1'b1; lt[0] = t; rs[0] = 64'(sum); rc[0] = cout; ro[0] = ovf; end
            if (!seen[1] && ov1)       begin seen[1] = 1'b1; lt[1] = t; rs[1] = 64'(s1);  rc[1] = co1;  ro[1] = of1;  end
            if (!seen[2] && ov16)      begin seen[2] = 1'b1; lt[2] = t; rs[2] = 64'(s16); rc[2] = co16; ro[2] = of16; end
            if (!seen[3] && ov8)       begin seen[3] = 1'b1; lt[3] = t; rs[3] = 64'(s8);  rc[3] = co8;  ro[3] = of8;  end
         end
         for (int i = 0; i < 4; i++) begin
            mask = (longint'(1) << wd[i]) - 1;
            model(wd[i], xa & mask, ya & mask, c, s, es, ec, eo);
            check($sformatf("rand%0d_w%0d_d%0d_latency", n, wd[i], wd[i] / nd[i]), lt[i], nd[i]);
            check($sformatf("rand%0d_w%0d_d%0d_cout_ovf_sum", n, wd[i], wd[i] / nd[i]),
                  (longint'(rc[i]) << 17) | (longint'(ro[i]) << 16) | rs[i],
                  (longint'(ec) << 17) | (longint'(eo) << 16) | es);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
